// File: rtl/alu_issue_if.sv
// Handshake bundle between the instruction source, the issue buffer and the ALU.
// The slave modport is the issue block's view; the master modport is the environment's.
interface alu_issue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_inst;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_op;
  logic [DATA_W-1:0] out_src1;
  logic [DATA_W-1:0] out_src2;
  logic              out_illegal;
  logic [15:0]       issue_count;

  modport slave (
    input  in_valid, in_inst, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_op, out_src1, out_src2, out_illegal, issue_count
  );

  modport master (
    output in_valid, in_inst, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_op, out_src1, out_src2, out_illegal, issue_count
  );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: decodes an instruction into ALU op/operands and queues it in a
// 2-entry FIFO toward the ALU, counting legal requests handed downstream.
module alu_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned DEPTH  = 2
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);

  typedef struct packed {
    logic              ill;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        r_live;
  logic [15:0] r_issue_count;

  entry_t      w_dec;
  entry_t      w_head;
  logic [4:0]  w_alu_op;
  logic        w_imm_sel;
  logic [15:0] w_imm16;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_unused_inst;

  assign w_alu_op      = bus.in_inst[31:27];
  assign w_imm_sel     = bus.in_inst[26];
  assign w_imm16       = bus.in_inst[15:0];
  assign w_unused_inst = ^bus.in_inst[25:16];

  always_comb begin
    w_dec = '0;
    if (w_alu_op <= 5'h0F) begin
      w_dec.op   = OP_W'(w_alu_op);
      w_dec.src1 = bus.in_rs1;
      w_dec.src2 = w_imm_sel ? {{(DATA_W-16){w_imm16[15]}}, w_imm16} : bus.in_rs2;
    end else if (w_alu_op == 5'h10) begin
      w_dec.op   = OP_W'(w_alu_op);
      w_dec.src1 = bus.in_rs1;
      w_dec.src2 = DATA_W'({w_imm16, 16'h0000});
    end else begin
      w_dec.ill = 1'b1;
    end
  end

  // r_live holds in_ready low through reset and for the first edge after it.
  assign w_in_ready  = r_live && (r_count < 2'(DEPTH));
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0]      <= '0;
      r_mem[1]      <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= 2'd0;
      r_live        <= 1'b0;
      r_issue_count <= 16'h0000;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_mem[r_wptr] <= w_dec;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
        if (!w_head.ill) r_issue_count <= r_issue_count + 16'h0001;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_op      = w_head.op;
  assign bus.out_src1    = w_head.src1;
  assign bus.out_src2    = w_head.src2;
  assign bus.out_illegal = w_head.ill;
  assign bus.issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: scoreboard of expected pops plus per-feature tasks.
module tb_alu_issue;

  typedef struct {
    logic        ill;
    logic [4:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  alu_issue_if #(.DATA_W(32), .OP_W(5)) bus ();

  alu_issue #(.DATA_W(32), .OP_W(5), .DEPTH(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] make_inst(input logic [4:0] op, input logic sel,
                                            input logic [15:0] imm);
    return {op, sel, 10'h000, imm};
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] rs1,
                                 input logic [31:0] rs2);
    exp_t e;
    e.ill = 1'b0; e.op = inst[31:27]; e.src1 = rs1;
    if (inst[31:27] == 5'h10) e.src2 = {inst[15:0], 16'h0000};
    else if (inst[31:27] > 5'h10) begin
      e.ill = 1'b1; e.op = 5'h00; e.src1 = 32'h0; e.src2 = 32'h0;
    end else if (inst[26]) e.src2 = {{16{inst[15]}}, inst[15:0]};
    else e.src2 = rs2;
    return e;
  endfunction

  // Scoreboard: record accepts, compare each pop against the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got op=%h with scoreboard empty", bus.out_op);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (bus.out_illegal !== e.ill || bus.out_op !== e.op ||
              bus.out_src1 !== e.src1 || bus.out_src2 !== e.src2) begin
            n_fail++;
            $display("FAIL pop_data: got ill=%b op=%h s1=%h s2=%h want ill=%b op=%h s1=%h s2=%h",
                     bus.out_illegal, bus.out_op, bus.out_src1, bus.out_src2,
                     e.ill, e.op, e.src1, e.src2);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.in_inst, bus.in_rs1, bus.in_rs2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic sel, input logic [15:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.in_valid = 1'b1;
    bus.in_inst  = make_inst(op, sel, imm);
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_inst = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    #3;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_op !== 5'h0 ||
        bus.out_src1 !== 32'h0 || bus.out_src2 !== 32'h0 || bus.out_illegal !== 1'b0 ||
        bus.issue_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b op=%h s1=%h s2=%h ill=%b cnt=%h want all 0",
               bus.out_valid, bus.in_ready, bus.out_op, bus.out_src1, bus.out_src2,
               bus.out_illegal, bus.issue_count);
    end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_release: got %b want 0", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_first_edge: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_register();
    bus.out_ready = 1'b1;
    drive(5'h01, 1'b0, 16'h0000, 32'd10, 32'd8);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 5'h01 || bus.out_src1 !== 32'd10 ||
        bus.out_src2 !== 32'd8) begin
      n_fail++;
      $display("FAIL reg_path: got v=%b op=%h s1=%0d s2=%0d want v=1 op=01 s1=10 s2=8",
               bus.out_valid, bus.out_op, bus.out_src1, bus.out_src2);
    end
    tick();
    n_checks++;
    if (bus.issue_count !== 16'd1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_count: got cnt=%0d v=%b want cnt=1 v=0", bus.issue_count, bus.out_valid);
    end
  endtask

  task automatic test_immediate();
    bus.out_ready = 1'b1;
    drive(5'h00, 1'b1, 16'hFFF8, 32'h55, 32'h77);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_src2 !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL imm_sext: got %h want fffffff8", bus.out_src2);
    end
    tick();
    drive(5'h10, 1'b0, 16'h1234, 32'hABCD, 32'h99);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_src2 !== 32'h1234_0000 || bus.out_op !== 5'h10 || bus.out_src1 !== 32'hABCD) begin
      n_fail++;
      $display("FAIL mvhi: got op=%h s1=%h s2=%h want op=10 s1=0000abcd s2=12340000",
               bus.out_op, bus.out_src1, bus.out_src2);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    base = bus.issue_count;
    bus.out_ready = 1'b0;
    drive(5'h02, 1'b0, 16'h0, 32'hA1, 32'hA2);
    tick();
    drive(5'h03, 1'b0, 16'h0, 32'hB1, 32'hB2);
    tick();
    drive(5'h04, 1'b0, 16'h0, 32'hC1, 32'hC2);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_op !== 5'h02 || bus.out_src1 !== 32'hA1) begin
      n_fail++;
      $display("FAIL bp_hold: got rdy=%b op=%h s1=%h want rdy=0 op=02 s1=a1",
               bus.in_ready, bus.out_op, bus.out_src1);
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_op !== 5'h03) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b op=%h want rdy=1 op=03", bus.in_ready, bus.out_op);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 5'h04 || bus.out_src1 !== 32'hC1) begin
      n_fail++;
      $display("FAIL bp_third: got v=%b op=%h s1=%h want v=1 op=04 s1=c1",
               bus.out_valid, bus.out_op, bus.out_src1);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.issue_count !== base + 16'd3) begin
      n_fail++;
      $display("FAIL bp_count: got v=%b cnt=%0d want v=0 cnt=%0d",
               bus.out_valid, bus.issue_count, base + 16'd3);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(5'(i), i[0], 16'(16'h8000 + i * 7), 32'(i * 3), 32'(i + 100));
      if (i > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_cycle%0d: got v=%b rdy=%b want v=1 rdy=1",
                   i, bus.out_valid, bus.in_ready);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.issue_count !== 16'd17 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_count: got cnt=%0d v=%b want cnt=17 v=0",
               bus.issue_count, bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] base;
    base = bus.issue_count;
    bus.out_ready = 1'b1;
    drive(5'h15, 1'b1, 16'h1234, 32'hDEAD, 32'hBEEF);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_illegal !== 1'b1 || bus.out_op !== 5'h0 || bus.out_src1 !== 32'h0 ||
        bus.out_src2 !== 32'h0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_entry: got v=%b ill=%b op=%h s1=%h s2=%h want v=1 ill=1 zeros",
               bus.out_valid, bus.out_illegal, bus.out_op, bus.out_src1, bus.out_src2);
    end
    tick();
    n_checks++;
    if (bus.issue_count !== base || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_count: got cnt=%0d v=%b want cnt=%0d v=0",
               bus.issue_count, bus.out_valid, base);
    end
  endtask

  task automatic test_reset_midop();
    bus.out_ready = 1'b0;
    drive(5'h05, 1'b0, 16'h0, 32'h1, 32'h2);
    tick();
    drive(5'h06, 1'b0, 16'h0, 32'h3, 32'h4);
    tick();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.issue_count !== 16'h0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b cnt=%0d rdy=%b want 0 0 0",
               bus.out_valid, bus.issue_count, bus.in_ready);
    end
    sb_q.delete();
    tick();
    reset = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    drive(5'h07, 1'b1, 16'h0010, 32'h70, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_op !== 5'h07 || bus.out_src2 !== 32'h10) begin
      n_fail++;
      $display("FAIL reset_resume: got v=%b op=%h s2=%h want v=1 op=07 s2=10",
               bus.out_valid, bus.out_op, bus.out_src2);
    end
    tick();
    n_checks++;
    if (bus.issue_count !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_resume_count: got %0d want 1", bus.issue_count);
    end
  endtask

  task automatic test_drain();
    int budget;
    budget = 20;
    bus.out_ready = 1'b1;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding want 0", sb_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_register();
    test_immediate();
    test_backpressure();
    test_streaming();
    test_illegal();
    test_reset_midop();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
